// File: rtl/pic_pkg.sv
// Shared types and register-field constants for the pic_lite interrupt controller.
package pic_pkg;

  typedef enum logic [1:0] {StUninit, StWaitIcw2, StReady} init_st_e;
  typedef enum logic [1:0] {StIdle, StAck1, StAck2} inta_st_e;

  // IR indices always fit in three bits because at most eight lines are supported.
  localparam int unsigned IdxW = 3;

  localparam int unsigned Icw1Bit    = 4;
  localparam int unsigned OcwSelBit  = 3;
  localparam int unsigned Ocw2EoiBit = 5;

  localparam logic [1:0] Ocw3RdIrr = 2'b10;
  localparam logic [1:0] Ocw3RdIsr = 2'b11;

  localparam logic [IdxW-1:0] SpuriousIdx = 3'd7;

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index-first priority encoder: index of the highest-priority set bit plus a valid flag.
module pic_prio_enc
  import pic_pkg::*;
#(
  parameter int unsigned NIr = 7
) (
  input  logic [NIr-1:0]  req_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(NIr) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_lite.sv
// Simplified 8259-style interrupt controller: edge-latched requests, mask, fixed nested priority,
// and a two-pulse INTA vector sequence.
module pic_lite
  import pic_pkg::*;
#(
  parameter int unsigned NIr = 7
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           cs_i,
  input  logic           wr_en_i,
  input  logic           rd_en_i,
  input  logic           a0_i,
  input  logic [7:0]     din_i,
  output logic [7:0]     dout_o,
  output logic           dout_oe_o,
  input  logic [NIr-1:0] ir_i,
  output logic           intr_o,
  input  logic           inta_ni
);

  init_st_e        init_q, init_d;
  inta_st_e        inta_st_q, inta_st_d;
  logic [NIr-1:0]  ir_s1_q, ir_s2_q, ir_s3_q;
  logic [NIr-1:0]  irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [4:0]      base_q, base_d;
  logic            rd_isr_q, rd_isr_d;
  logic [IdxW-1:0] vec_q, vec_d;
  logic            inta_q, intr_q, intr_d;

  logic            wr, rd_req, icw1, icw2, imr_w, ocw_w, ocw2, ocw3, fall, rise, ack_take;
  logic            ready, pend_valid, isr_valid, nest_ok, vec_drv;
  logic [NIr-1:0]  pend, edges, hp_mask, hs_mask;
  logic [IdxW-1:0] hp, hs;

  assign wr     = cs_i & wr_en_i;
  assign rd_req = cs_i & rd_en_i;
  assign ready  = (init_q == StReady);
  assign icw1   = wr & ~a0_i & din_i[Icw1Bit];
  assign icw2   = wr & a0_i & (init_q == StWaitIcw2);
  assign imr_w  = wr & a0_i & ready;
  assign ocw_w  = wr & ~a0_i & ~din_i[Icw1Bit] & ready;
  assign ocw2   = ocw_w & ~din_i[OcwSelBit];
  assign ocw3   = ocw_w & din_i[OcwSelBit];

  assign fall     = inta_q & ~inta_ni;
  assign rise     = ~inta_q & inta_ni;
  assign ack_take = (inta_st_q == StIdle) & fall & ~icw1;

  assign pend    = irr_q & ~imr_q;
  assign edges   = ir_s2_q & ~ir_s3_q;
  assign hp_mask = NIr'(1) << hp;
  assign hs_mask = NIr'(1) << hs;
  // An empty ISR behaves as index NIr, so any pending request outranks it.
  assign nest_ok = ~isr_valid | (hp < hs);
  assign vec_drv = (inta_st_q == StAck2) & ~inta_ni;

  pic_prio_enc #(.NIr(NIr)) u_pend_enc (
    .req_i   (pend),
    .idx_o   (hp),
    .valid_o (pend_valid)
  );

  pic_prio_enc #(.NIr(NIr)) u_isr_enc (
    .req_i   (isr_q),
    .idx_o   (hs),
    .valid_o (isr_valid)
  );

  always_comb begin
    init_d    = init_q;
    inta_st_d = inta_st_q;
    irr_d     = irr_q;
    isr_d     = isr_q;
    imr_d     = imr_q;
    base_d    = base_q;
    rd_isr_d  = rd_isr_q;
    vec_d     = vec_q;
    if (icw1) begin
      irr_d     = '0;
      isr_d     = '0;
      imr_d     = '0;
      rd_isr_d  = 1'b0;
      init_d    = StWaitIcw2;
      inta_st_d = StIdle;
    end else begin
      if (icw2) begin
        base_d = din_i[7:3];
        init_d = StReady;
      end
      if (imr_w) imr_d = din_i[NIr-1:0];
      if (ocw2 && din_i[Ocw2EoiBit] && isr_valid) isr_d = isr_d & ~hs_mask;
      if (ocw3) begin
        if (din_i[1:0] == Ocw3RdIrr) rd_isr_d = 1'b0;
        else if (din_i[1:0] == Ocw3RdIsr) rd_isr_d = 1'b1;
      end
      unique case (inta_st_q)
        StIdle: begin
          if (fall) begin
            inta_st_d = StAck1;
            vec_d     = pend_valid ? hp : SpuriousIdx;
            if (pend_valid) begin
              isr_d = isr_d | hp_mask;
              irr_d = irr_d & ~hp_mask;
            end
          end
        end
        StAck1:  if (rise) inta_st_d = StAck2;
        StAck2:  if (rise) inta_st_d = StIdle;
        default: inta_st_d = StIdle;
      endcase
    end
    // A new edge wins over any clear of the same bit.
    irr_d  = irr_d | edges;
    intr_d = ready & pend_valid & nest_ok & ~ack_take & ~icw1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q    <= StUninit;
      inta_st_q <= StIdle;
      ir_s1_q   <= '0;
      ir_s2_q   <= '0;
      ir_s3_q   <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      imr_q     <= '0;
      base_q    <= '0;
      rd_isr_q  <= 1'b0;
      vec_q     <= '0;
      inta_q    <= 1'b1;
      intr_q    <= 1'b0;
    end else begin
      init_q    <= init_d;
      inta_st_q <= inta_st_d;
      ir_s1_q   <= ir_i;
      ir_s2_q   <= ir_s1_q;
      ir_s3_q   <= ir_s2_q;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      base_q    <= base_d;
      rd_isr_q  <= rd_isr_d;
      vec_q     <= vec_d;
      inta_q    <= inta_ni;
      intr_q    <= intr_d;
    end
  end

  always_comb begin
    dout_o    = 8'h00;
    dout_oe_o = rd_req | vec_drv;
    if (rd_req) begin
      if (a0_i)          dout_o = 8'(imr_q);
      else if (rd_isr_q) dout_o = 8'(isr_q);
      else               dout_o = 8'(irr_q);
    end else if (vec_drv) begin
      dout_o = {base_q, vec_q};
    end
  end

  assign intr_o = intr_q;

  rd_in_ack2_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((inta_st_q == StAck2) && rd_req));

endmodule

// File: doc/pic_lite.md
# pic_lite

Simplified 8259-style programmable interrupt controller for the 8088 system. It sits between the external interrupt lines (`ir_ext`) and the CPU core's INTR/INTA pins, and is selected by the I/O address decoder through `cs`. It latches edge-triggered requests, applies a mask and fixed priority, and supplies an 8-bit interrupt vector during the CPU's two-pulse interrupt-acknowledge sequence.

## Interface
- `N_IR`, 7: number of request inputs, 1..8; IR index 0 has the highest priority.
- `clk`  in  1: system clock. All logic is clocked on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs`  in  1: chip select from the I/O decoder.
- `wr_en`  in  1: one-cycle write strobe. Only valid while `cs`=1.
- `rd_en`  in  1: read enable. Only valid while `cs`=1.
- `a0`  in  1: register select (CPU A0).
- `din`  in  8: write data.
- `dout`  out  8: read data, or the vector during the second INTA pulse.
- `dout_oe`  out  1: `dout` is valid (register read or vector drive).
- `ir`  in  N_IR: asynchronous interrupt request lines.
- `intr`  out  1: interrupt request to the CPU. Registered.
- `inta_n`  in  1: CPU interrupt acknowledge, active low. Synchronous to `clk`.

## Operation
**Init FSM** (states UNINIT → WAIT_ICW2 → READY)
- A write with `a0`=0 and `din[4]`=1 is ICW1. It is accepted in any state:
  - clears IRR, ISR, IMR, the OCW3 select and the INTA FSM;
  - moves the init FSM to WAIT_ICW2.
- In WAIT_ICW2, a write with `a0`=1 is ICW2: `base` ← `din[7:3]`, and the FSM moves to READY.
- In UNINIT and WAIT_ICW2, `intr`=0. IRR still latches edges.

**Writes in READY**
- `a0`=1: IMR ← `din[N_IR-1:0]`.
- `a0`=0, `din[4:3]`=00: OCW2.
  - If `din[5]`=1 (non-specific EOI), clear the highest-priority set ISR bit.
  - If ISR is empty, EOI does nothing.
- `a0`=0, `din[4:3]`=01: OCW3.
  - `din[1:0]`=10 selects IRR for reads.
  - `din[1:0]`=11 selects ISR for reads.
  - Any other value leaves the select unchanged.

**Reads** (combinational; `dout_oe`=`cs`&`rd_en`)
- `a0`=1 returns IMR.
- `a0`=0 returns IRR or ISR, per the OCW3 select (IRR after reset or ICW1).
- Unused upper bits read 0.
- When `dout_oe`=0 and no vector is being driven, `dout`=0.

**Requests**
- Each `ir` bit passes through a 2-flop synchronizer.
- A rising edge of the synchronized bit sets the IRR bit. Masking does not prevent the IRR bit from being set.
- `pend` = IRR & ~IMR.
- Let `hp` be the lowest set index in `pend`, and `hs` the lowest set index in ISR (`hs` = N_IR if ISR is empty).
- Next `intr` = READY & (`pend` is non-zero) & (`hp` < `hs`), which gives fully nested fixed priority.

**INTA FSM** (states IDLE → ACK1 → ACK2 → IDLE)
- A falling edge is `inta_n` low while its previous registered value was high.
- First falling edge (IDLE→ACK1):
  - latch `vec_irq` = `hp`, set ISR[`hp`], clear IRR[`hp`];
  - force `intr`=0 next cycle.
  - If `pend` is empty (spurious acknowledge), `vec_irq`=7 and ISR/IRR are unchanged.
- Rising `inta_n` moves ACK1→ACK2.
- Second falling edge, and while `inta_n` stays low: `dout` = {`base`, `vec_irq[2:0]`} and `dout_oe`=1.
- Rising `inta_n` returns the FSM to IDLE.

**Collisions and overrides**
- IRR set and clear on the same bit in the same cycle: set wins.
- ICW1 during ACK1 or ACK2 aborts the FSM to IDLE. ISR is cleared as part of ICW1.
- A register read has priority over vector drive only if `cs`&`rd_en` is asserted during ACK2. The bus must not do this; an assertion flags it.

## Timing
- **Reset values:** `intr`=0, `dout`=0, `dout_oe`=0, IRR/ISR/IMR=0, `base`=0, init FSM=UNINIT, INTA FSM=IDLE.
- **`ir` → `intr` latency:** if `ir` goes high before clock edge k, the synchronizer output is high at k+1, IRR is set at k+2, and `intr` is high at k+3.
- **`intr` deassertion:** `intr` drops the cycle after the first INTA falling edge is detected.
- **Register writes:** take effect on the `wr_en` clock edge. A mask or EOI write affects `intr` one cycle later.
- **Vector output:** `dout` and `dout_oe` show the vector in the same cycle the second `inta_n` low is seen. The path from `inta_n` to `dout` is combinational, from the FSM state and the `inta_n` input.

## Structure
- Package `pic_pkg` holds:
  - the init-state and INTA-state enums;
  - ICW1/OCW2/OCW3 bit-position constants;
  - the spurious IR index constant (7).
- Sub-module `pic_prio_enc`: a combinational lowest-index-first encoder (N_IR bits → index plus valid flag). It is instantiated twice, once for `pend` and once for ISR.

## Test plan
- **Basic request:** write ICW1=0x13, ICW2=0x08, IMR=0x00, then pulse `ir[0]`.
  - `intr`=1 exactly 3 cycles later.
  - Two INTA pulses → `dout`=0x08 with `dout_oe`=1 on the second pulse.
  - ISR reads 0x01 (after OCW3=0x0B); OCW2=0x20 → ISR reads 0x00.
- **Simultaneous requests:** `ir[3]` and `ir[1]` rise in the same cycle.
  - First acknowledge gives vector 0x09.
  - After EOI, `intr` reasserts; second acknowledge gives vector 0x0B.
- **Masking:** IMR=0x02, pulse `ir[1]`.
  - `intr` stays 0, and IRR reads 0x02 (OCW3=0x0A).
  - Writing IMR=0x00 → `intr`=1 one cycle later.
- **Nesting:** `ir[2]` is in service.
  - `ir[5]` rises → no `intr` until EOI.
  - `ir[0]` rises → `intr`=1 while ISR=0x04.
- **Spurious acknowledge:** INTA with `pend`=0 → vector 0x0F; ISR is unchanged.
- **Reset and abort:**
  - Assert `rst_n` low during ACK1 → all outputs 0 and both FSMs idle, immediately (asynchronously).
  - ICW1 during ACK2 → FSM returns to IDLE and no vector is driven.
